// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: scheduler state encoding, block geometry and the
// small/large sigma functions used by the schedule and compression stages.
package sha256_pkg;

    localparam int unsigned SHA_WORDS  = 16;
    localparam int unsigned SHA_ROUNDS = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } sched_state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_wnext.sv
// Combinational next schedule word: sigma1(w14) + w9 + sigma0(w1) + w0, mod 2^32.
module sha256_wnext
    import sha256_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w9,
    input  logic [31:0] w14,
    output logic [31:0] wnew
);

    always_comb begin
        wnew = sigma1(w14) + w9 + sigma0(w1) + w0;
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule and round sequencer: 16-word sliding window, 64 rounds.
// Optional round stall input enabled by defining SHA256_SCHED_STALL_EN.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] msg,
`ifdef SHA256_SCHED_STALL_EN
    input  logic         stall,
`endif
    output logic         start_ready,
    output logic [5:0]   count,
    output logic [31:0]  wt,
    output logic         round_valid,
    output logic         done
);

    if (ROUNDS != SHA_ROUNDS) begin : g_rounds_check
        $error("sha256_msg_sched: ROUNDS must equal 64");
    end

    sched_state_e state_q, state_d;
    logic [5:0]   count_q, count_d;
    logic [31:0]  w_q [SHA_WORDS];
    logic [31:0]  w_d [SHA_WORDS];
    logic [31:0]  wnew;
    logic         advance;

    always_comb begin
        advance = (state_q == StRound);
`ifdef SHA256_SCHED_STALL_EN
        if (stall) begin
            advance = 1'b0;
        end
`endif
    end

    sha256_wnext u_wnext (
        .w0   (w_q[0]),
        .w1   (w_q[1]),
        .w9   (w_q[9]),
        .w14  (w_q[14]),
        .wnew (wnew)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        w_d     = w_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRound;
                    count_d = '0;
                    // Big-endian word order: W0 sits in the top 32 bits.
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = msg[511 - 32 * i -: 32];
                    end
                end
            end
            StRound: begin
                if (advance) begin
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i + 1];
                    end
                    w_d[15] = wnew;
                    if (count_q == 6'(SHA_ROUNDS - 1)) begin
                        state_d = StDone;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                count_d = '0;
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // wt is the head of the window register, so it is registered by construction.
    assign wt          = w_q[0];
    assign count       = count_q;
    assign start_ready = (state_q == StIdle);
    assign done        = (state_q == StDone);
    assign round_valid = advance;

endmodule
